fifo_arbiter: RTL and testbench

FIFO_ARBITER -- requirements
Module: fifo_arbiter

---
 rtl/fifo_arbiter.sv | 143 ++++++++++++++
 tb/tb_fifo_arbiter.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_arbiter.sv
// fifo_arbiter: round-robin drain of four source FIFOs into one destination FIFO.
// One grant per edge at most. The granted word shows up on the source FIFO's
// buff_out one edge later, and it is pushed downstream on the edge after that.

// Per-queue eligibility cell.
module fifo_arbiter_lane (
  input  logic en_i,
  input  logic empty_i,
  input  logic popped_i,
  output logic elig_o
);
  // A queue popped on the previous edge still shows its old empty flag, so skip it.
  assign elig_o = en_i & ~empty_i & ~popped_i;
endmodule

module fifo_arbiter #(
  parameter  int DATA_SIZE = 6,
  localparam int N_QUEUES  = 4
) (
  input  logic                          clk,
  input  logic                          reset_L,
  input  logic [N_QUEUES-1:0]           enable,
  input  logic [N_QUEUES-1:0]           src_empty,
  input  logic [N_QUEUES*DATA_SIZE-1:0] src_data,
  input  logic                          dst_almost_full,
  input  logic                          dst_full,
  output logic [N_QUEUES-1:0]           pop,
  output logic                          push,
  output logic [DATA_SIZE-1:0]          data_out,
  output logic [1:0]                    state,
  output logic [15:0]                   push_count
);
  localparam int QW     = $clog2(N_QUEUES);
  localparam int STAGES = 2;

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DRAIN = 2'd2} state_e;

  state_e                          state_q, state_d;
  logic [N_QUEUES-1:0]             pop_q, pop_d;
  logic                            push_q, push_d;
  logic [DATA_SIZE-1:0]            data_q, data_d;
  logic [15:0]                     cnt_q, cnt_d;
  logic [QW-1:0]                   rr_q, rr_d;
  logic [STAGES:1]                 vld_pipe_q, vld_pipe_d;
  logic [STAGES:1][QW-1:0]         tag_pipe_q, tag_pipe_d;

  logic [N_QUEUES-1:0]             elig;
  logic [N_QUEUES-1:0][DATA_SIZE-1:0] src_words;
  logic                            bp, pend, hit, grant;
  logic [QW-1:0]                   gnt_idx, idx;

  assign src_words = src_data;
  assign bp        = dst_almost_full | dst_full;
  assign pend      = |vld_pipe_q;

  for (genvar i = 0; i < N_QUEUES; i++) begin : g_lane
    fifo_arbiter_lane u_lane (
      .en_i     (enable[i]),
      .empty_i  (src_empty[i]),
      .popped_i (pop_q[i]),
      .elig_o   (elig[i])
    );
  end

  // Round-robin pick: walk offsets high to low so the smallest offset from rr_q wins.
  always_comb begin
    hit     = 1'b0;
    gnt_idx = rr_q;
    idx     = rr_q;
    for (int i = N_QUEUES-1; i >= 0; i--) begin
      idx = rr_q + QW'(i);
      if (elig[idx]) begin
        hit     = 1'b1;
        gnt_idx = idx;
      end
    end
    grant = hit & ~bp;
  end

  // FSM next state; a grant is only ever issued when the next state is RUN.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (grant) state_d = RUN;
      RUN:     if (!grant) state_d = pend ? DRAIN : IDLE;
      DRAIN:   if (grant) state_d = RUN;
               else if (!pend) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath next state: pop strobe, pointer, tag pipeline, push and counter.
  always_comb begin
    pop_d = '0;
    rr_d  = rr_q;
    if (grant) begin
      pop_d[gnt_idx] = 1'b1;
      rr_d           = gnt_idx + QW'(1);
    end
    vld_pipe_d = {vld_pipe_q[STAGES-1:1], grant};
    tag_pipe_d = {tag_pipe_q[STAGES-1:1], gnt_idx};
    push_d     = vld_pipe_q[STAGES];
    data_d     = data_q;
    cnt_d      = cnt_q;
    if (vld_pipe_q[STAGES]) begin
      data_d = src_words[tag_pipe_q[STAGES]];
      cnt_d  = cnt_q + 16'd1;
    end
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (!reset_L) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // Datapath registers; reset drops anything in flight.
  always_ff @(posedge clk) begin
    if (!reset_L) begin
      pop_q      <= '0;
      push_q     <= 1'b0;
      data_q     <= '0;
      cnt_q      <= '0;
      rr_q       <= '0;
      vld_pipe_q <= '0;
      tag_pipe_q <= '0;
    end else begin
      pop_q      <= pop_d;
      push_q     <= push_d;
      data_q     <= data_d;
      cnt_q      <= cnt_d;
      rr_q       <= rr_d;
      vld_pipe_q <= vld_pipe_d;
      tag_pipe_q <= tag_pipe_d;
    end
  end

  assign pop        = pop_q;
  assign push       = push_q;
  assign data_out   = data_q;
  assign state      = state_q;
  assign push_count = cnt_q;
endmodule

// File: tb/tb_fifo_arbiter.sv
// Bench for fifo_arbiter: source FIFO models plus a queue-based reference of the
// arbiter, compared every cycle, with directed scenarios pinned by literals.
module tb_fifo_arbiter;
  localparam int DW = 6;
  localparam int NQ = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              reset_L;
  logic [NQ-1:0]     enable, src_empty;
  logic [NQ*DW-1:0]  src_data;
  logic              dst_almost_full, dst_full;
  logic [NQ-1:0]     pop;
  logic              push;
  logic [DW-1:0]     data_out;
  logic [1:0]        state;
  logic [15:0]       push_count;

  fifo_arbiter #(.DATA_SIZE(DW)) dut (
    .clk(clk), .reset_L(reset_L), .enable(enable), .src_empty(src_empty),
    .src_data(src_data), .dst_almost_full(dst_almost_full), .dst_full(dst_full),
    .pop(pop), .push(push), .data_out(data_out), .state(state), .push_count(push_count)
  );

  int total = 0;
  int bad   = 0;
  bit chk_on = 1'b0;

  // source FIFOs: unread words and the registered read output
  logic [DW-1:0] fq [NQ][$];
  logic [DW-1:0] buff [NQ];

  // reference: list of granted words with the edge number they must be pushed on
  typedef struct { int g; int due; } fl_t;
  fl_t fl[$];
  logic [NQ-1:0] m_pop  = '0;
  logic          m_push = 1'b0;
  logic [DW-1:0] m_dout = '0;
  int            m_state = 0;
  logic [15:0]   m_cnt = '0;
  int            m_rr  = 0;
  int            cyc   = 0;

  task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s @%0t: got %0h, want %0h", nm, $time, act, exp);
    end
  endtask

  task automatic drive_srcs();
    for (int i = 0; i < NQ; i++) begin
      src_empty[i]          = (fq[i].size() == 0);
      src_data[i*DW +: DW]  = buff[i];
    end
  endtask

  task automatic fill(input int q, input int n);
    repeat (n) fq[q].push_back(DW'($urandom));
  endtask

  // Advance reference and source FIFOs by one edge using the inputs applied before it.
  task automatic step();
    logic [NQ-1:0] pop_prev, el;
    logic bp;
    bit   pend;
    int   g;
    pop_prev = m_pop;
    if (!reset_L) begin
      m_pop = '0; m_push = 1'b0; m_dout = '0; m_state = 0; m_cnt = '0; m_rr = 0;
      fl.delete();
    end else begin
      bp   = dst_almost_full | dst_full;
      pend = (fl.size() != 0);
      for (int i = 0; i < NQ; i++) el[i] = enable[i] & ~src_empty[i] & ~m_pop[i];
      g = -1;
      if (!bp)
        for (int k = 0; k < NQ; k++)
          if (g < 0 && el[(m_rr + k) % NQ]) g = (m_rr + k) % NQ;
      m_push = 1'b0;
      if (pend && fl[0].due == cyc) begin
        m_push = 1'b1;
        m_dout = buff[fl[0].g];
        m_cnt  = m_cnt + 16'd1;
        void'(fl.pop_front());
      end
      m_pop = '0;
      if (g >= 0) begin
        m_pop[g] = 1'b1;
        m_rr     = (g + 1) % NQ;
        fl.push_back('{g: g, due: cyc + 2});
      end
      case (m_state)
        0: if (g >= 0) m_state = 1;
        1: if (g < 0) m_state = pend ? 2 : 0;
        default: if (g >= 0) m_state = 1; else if (!pend) m_state = 0;
      endcase
    end
    for (int i = 0; i < NQ; i++)
      if (pop_prev[i] && fq[i].size() != 0) buff[i] = fq[i].pop_front();
    cyc++;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    step();
    drive_srcs();
  endtask

  task automatic restart();
    reset_L = 1'b0; dst_almost_full = 1'b0; dst_full = 1'b0;
    for (int i = 0; i < NQ; i++) fq[i].delete();
    drive_srcs();
    tick(); tick();
    reset_L = 1'b1;
  endtask

  // every-cycle comparison against the reference
  always @(negedge clk) begin
    if (chk_on) begin
      cmp("pop",        32'(pop),        32'(m_pop));
      cmp("push",       32'(push),       32'(m_push));
      cmp("data_out",   32'(data_out),   32'(m_dout));
      cmp("state",      32'(state),      32'(m_state));
      cmp("push_count", 32'(push_count), 32'(m_cnt));
    end
  end

  initial begin
    logic [NQ-1:0] rr_seq [5];
    logic [NQ-1:0] mk_seq [8];
    int npush;
    rr_seq = '{4'h1, 4'h2, 4'h4, 4'h8, 4'h1};
    mk_seq = '{4'h1, 4'h0, 4'h1, 4'h0, 4'h1, 4'h0, 4'h0, 4'h0};
    for (int i = 0; i < NQ; i++) buff[i] = '0;
    reset_L = 1'b0; enable = 4'hF; dst_almost_full = 1'b0; dst_full = 1'b0;
    src_data = '0;

    // reset held two edges with every queue non-empty
    for (int i = 0; i < NQ; i++) fill(i, 4);
    drive_srcs();
    tick(); chk_on = 1'b1;
    tick();
    cmp("rst_pop", 32'(pop), 32'h0);
    cmp("rst_push", 32'(push), 32'h0);
    cmp("rst_data", 32'(data_out), 32'h0);
    cmp("rst_state", 32'(state), 32'h0);
    cmp("rst_cnt", 32'(push_count), 32'h0);

    // single word in queue 2
    restart(); enable = 4'hF;
    fq[2].push_back(6'h15); drive_srcs();
    tick(); cmp("one_pop", 32'(pop), 32'h4); cmp("one_state_run", 32'(state), 32'h1);
    tick(); cmp("one_pop_off", 32'(pop), 32'h0); cmp("one_nopush", 32'(push), 32'h0);
    tick(); cmp("one_push", 32'(push), 32'h1); cmp("one_data", 32'(data_out), 32'h15);
    tick(); cmp("one_idle", 32'(state), 32'h0); cmp("one_hold", 32'(data_out), 32'h15);
    cmp("one_push_off", 32'(push), 32'h0);

    // round robin over four busy queues
    restart(); enable = 4'hF;
    for (int i = 0; i < NQ; i++) fill(i, 4);
    drive_srcs();
    for (int k = 0; k < 5; k++) begin
      tick();
      cmp("rr_pop", 32'(pop), 32'(rr_seq[k]));
      if (k >= 2) cmp("rr_push", 32'(push), 32'h1);
    end
    tick(); cmp("rr_push6", 32'(push), 32'h1); cmp("rr_cnt4", 32'(push_count), 32'h4);
    enable = 4'h0; repeat (4) tick();

    // backpressure after two grants
    restart(); enable = 4'hF;
    for (int i = 0; i < NQ; i++) fill(i, 4);
    drive_srcs();
    tick(); tick();
    dst_almost_full = 1'b1;
    tick(); cmp("bp_pop3", 32'(pop), 32'h0); cmp("bp_push3", 32'(push), 32'h1);
    cmp("bp_drain3", 32'(state), 32'h2);
    tick(); cmp("bp_pop4", 32'(pop), 32'h0); cmp("bp_push4", 32'(push), 32'h1);
    cmp("bp_drain4", 32'(state), 32'h2);
    tick(); cmp("bp_push5", 32'(push), 32'h0); cmp("bp_idle", 32'(state), 32'h0);
    cmp("bp_cnt", 32'(push_count), 32'h2);
    tick(); cmp("bp_pop6", 32'(pop), 32'h0);
    dst_almost_full = 1'b0;
    tick(); cmp("bp_resume", 32'(pop), 32'h4); cmp("bp_run", 32'(state), 32'h1);
    enable = 4'h0; repeat (4) tick();

    // single enabled queue cannot be popped on consecutive edges
    restart(); enable = 4'b0001;
    fill(0, 3); fill(1, 2); fill(3, 2); drive_srcs();
    npush = 0;
    for (int k = 0; k < 9; k++) begin
      tick();
      if (k < 8) cmp("mask_pop", 32'(pop), 32'(mk_seq[k]));
      if (push) npush++;
    end
    cmp("mask_pushes", 32'(npush), 32'h3);
    cmp("mask_cnt", 32'(push_count), 32'h3);

    // randomized traffic with backpressure and occasional reset
    restart();
    for (int n = 0; n < 3000; n++) begin
      enable          = NQ'($urandom);
      dst_almost_full = ($urandom_range(0, 7) == 0);
      dst_full        = ($urandom_range(0, 15) == 0);
      reset_L         = ($urandom_range(0, 199) != 0);
      for (int i = 0; i < NQ; i++)
        if ($urandom_range(0, 2) == 0 && fq[i].size() < 6) fill(i, 1);
      drive_srcs();
      tick();
    end
    reset_L = 1'b1; dst_almost_full = 1'b0; dst_full = 1'b0;

    // counter wrap under sustained traffic
    restart(); enable = 4'hF;
    begin
      int n;
      n = 0;
      while (m_cnt != 16'hFFFF && n < 70000) begin
        for (int i = 0; i < NQ; i++) if (fq[i].size() < 3) fill(i, 3);
        drive_srcs();
        tick();
        n++;
      end
      if (m_cnt != 16'hFFFF) begin
        total++; bad++;
        $display("FAIL wrap_reach: count %0h after %0d cycles, want ffff", m_cnt, n);
      end
    end
    cmp("wrap_ffff", 32'(push_count), 32'hFFFF);
    for (int i = 0; i < NQ; i++) if (fq[i].size() < 3) fill(i, 3);
    drive_srcs();
    tick(); cmp("wrap_push", 32'(push), 32'h1); cmp("wrap_zero", 32'(push_count), 32'h0);

    // reset one edge after a pop discards the in-flight word
    enable = 4'h0; repeat (4) tick();
    enable = 4'b0010; drive_srcs();
    tick(); cmp("rf_pop", 32'(pop), 32'h2);
    reset_L = 1'b0;
    tick(); cmp("rf_push1", 32'(push), 32'h0); cmp("rf_pop1", 32'(pop), 32'h0);
    reset_L = 1'b1; enable = 4'h0;
    tick(); cmp("rf_push2", 32'(push), 32'h0);
    tick(); cmp("rf_push3", 32'(push), 32'h0); cmp("rf_cnt", 32'(push_count), 32'h0);

    chk_on = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
